// File: rtl/mu0_control_fsm.sv
// -----------------------------------------------------------------------------
// mu0_control_fsm
//
// Purpose:
//   Control unit for the MU0 16-bit accumulator machine. A three-state
//   machine (FETCH, EXEC, HALT) sequences every instruction as one fetch
//   cycle followed by one execute cycle. The datapath control word is
//   decoded combinationally from the current state, the opcode and the
//   accumulator flags, so a new control word takes effect in the same
//   cycle the state changes.
//
// Ports:
//   i_clk        system clock, rising edge active
//   i_reset      asynchronous active-high reset, forces FETCH immediately
//   i_f[3:0]     opcode field IR[15:12], only looked at in EXEC
//   i_n          accumulator negative flag (Acc[15])
//   i_z          accumulator zero flag (Acc == 0)
//   o_x_sel      ALU X operand: 0 = Acc, 1 = PC
//   o_y_sel      ALU Y operand: 0 = Din, 1 = IR
//   o_addr_sel   memory address: 0 = PC, 1 = IR[11:0]
//   o_m[1:0]     ALU mode: 0 Q=Y, 1 X+Y, 2 X+1, 3 X-Y
//   o_pc_en      PC load enable
//   o_ir_en      IR load enable
//   o_acc_en     Acc load enable
//   o_rd         memory read strobe
//   o_wr         memory write strobe
//   o_fetch      high while in FETCH (and while reset is held)
//   o_halted     high while in HALT
// -----------------------------------------------------------------------------
module mu0_control_fsm (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_f,
  input  logic       i_n,
  input  logic       i_z,
  output logic       o_x_sel,
  output logic       o_y_sel,
  output logic       o_addr_sel,
  output logic [1:0] o_m,
  output logic       o_pc_en,
  output logic       o_ir_en,
  output logic       o_acc_en,
  output logic       o_rd,
  output logic       o_wr,
  output logic       o_fetch,
  output logic       o_halted
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // ALU modes
  localparam logic [1:0] M_PASS_Y = 2'd0;
  localparam logic [1:0] M_ADD    = 2'd1;
  localparam logic [1:0] M_INC_X  = 2'd2;
  localparam logic [1:0] M_SUB    = 2'd3;

  // Opcodes
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  // Datapath control word; every field defaults to 0 so unused selects and
  // modes are never left floating.
  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic [1:0] m;
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic       rd;
    logic       wr;
  } ctrl_t;

  state_t r_state;
  ctrl_t  w_ctrl;
  logic   w_stop;

  // STP and every undefined opcode (bit 3 set) end execution.
  assign w_stop = (i_f == OP_STP) || i_f[3];

  // ---------------------------------------------------------------------------
  // State register. Unused encoding falls back to FETCH.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC:  r_state <= w_stop ? ST_HALT : ST_FETCH;
        ST_HALT:  r_state <= ST_HALT;
        default:  r_state <= ST_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control decode. Reset is folded in combinationally so that enables and
  // strobes drop the instant reset rises, before the state register has
  // been seen to change by anything downstream.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ctrl = '0;
    if (!i_reset) begin
      case (r_state)
        ST_FETCH: begin
          // Read M[PC] into IR while computing PC+1 into PC.
          w_ctrl.addr_sel = 1'b0;
          w_ctrl.rd       = 1'b1;
          w_ctrl.ir_en    = 1'b1;
          w_ctrl.x_sel    = 1'b1;
          w_ctrl.m        = M_INC_X;
          w_ctrl.pc_en    = 1'b1;
        end

        ST_EXEC: begin
          case (i_f)
            OP_LDA: begin
              w_ctrl.addr_sel = 1'b1;
              w_ctrl.rd       = 1'b1;
              w_ctrl.y_sel    = 1'b0;
              w_ctrl.m        = M_PASS_Y;
              w_ctrl.acc_en   = 1'b1;
            end
            OP_STA: begin
              // Acc drives the data bus through the X path.
              w_ctrl.addr_sel = 1'b1;
              w_ctrl.wr       = 1'b1;
              w_ctrl.x_sel    = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              w_ctrl.addr_sel = 1'b1;
              w_ctrl.rd       = 1'b1;
              w_ctrl.x_sel    = 1'b0;
              w_ctrl.y_sel    = 1'b0;
              w_ctrl.m        = (i_f == OP_ADD) ? M_ADD : M_SUB;
              w_ctrl.acc_en   = 1'b1;
            end
            OP_JMP: begin
              w_ctrl.y_sel = 1'b1;
              w_ctrl.m     = M_PASS_Y;
              w_ctrl.pc_en = 1'b1;
            end
            OP_JGE: begin
              // Not-taken branch leaves the whole word at 0.
              if (!i_n) begin
                w_ctrl.y_sel = 1'b1;
                w_ctrl.m     = M_PASS_Y;
                w_ctrl.pc_en = 1'b1;
              end
            end
            OP_JNE: begin
              if (!i_z) begin
                w_ctrl.y_sel = 1'b1;
                w_ctrl.m     = M_PASS_Y;
                w_ctrl.pc_en = 1'b1;
              end
            end
            default: begin
              // STP and undefined opcodes: nothing moves.
              w_ctrl = '0;
            end
          endcase
        end

        default: begin
          // HALT: everything idle.
          w_ctrl = '0;
        end
      endcase
    end
  end

  assign o_x_sel    = w_ctrl.x_sel;
  assign o_y_sel    = w_ctrl.y_sel;
  assign o_addr_sel = w_ctrl.addr_sel;
  assign o_m        = w_ctrl.m;
  assign o_pc_en    = w_ctrl.pc_en;
  assign o_ir_en    = w_ctrl.ir_en;
  assign o_acc_en   = w_ctrl.acc_en;
  assign o_rd       = w_ctrl.rd;
  assign o_wr       = w_ctrl.wr;

  // While reset is held the machine is considered to be sitting in FETCH.
  assign o_fetch  = i_reset || (r_state == ST_FETCH);
  assign o_halted = !i_reset && (r_state == ST_HALT);

endmodule

// File: tb/tb_mu0_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mu0_control_fsm
//
// Purpose:
//   Self-checking bench for mu0_control_fsm. Stimulus is a stream of
//   instructions; the expected control word for every cycle comes from an
//   instruction-level model (fetch word, per-opcode execute word, halt word,
//   reset word). A few directed instructions are checked against literal
//   words to pin the model.
// -----------------------------------------------------------------------------
module tb_mu0_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] f;
  logic       n;
  logic       z;
  logic       x_sel, y_sel, addr_sel;
  logic [1:0] m;
  logic       pc_en, ir_en, acc_en, rd, wr, fetch, halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mu0_control_fsm dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_f        (f),
    .i_n        (n),
    .i_z        (z),
    .o_x_sel    (x_sel),
    .o_y_sel    (y_sel),
    .o_addr_sel (addr_sel),
    .o_m        (m),
    .o_pc_en    (pc_en),
    .o_ir_en    (ir_en),
    .o_acc_en   (acc_en),
    .o_rd       (rd),
    .o_wr       (wr),
    .o_fetch    (fetch),
    .o_halted   (halted)
  );

  // Observed word: {x_sel, y_sel, addr_sel, m[1:0], pc_en, ir_en, acc_en, rd, wr, fetch, halted}
  logic [11:0] w_dut;
  assign w_dut = {x_sel, y_sel, addr_sel, m, pc_en, ir_en, acc_en, rd, wr, fetch, halted};

  function automatic logic [11:0] pack(input logic xs, input logic ys, input logic as,
                                       input logic [1:0] mm, input logic pc, input logic ir,
                                       input logic acc, input logic r, input logic w,
                                       input logic fe, input logic ha);
    return {xs, ys, as, mm, pc, ir, acc, r, w, fe, ha};
  endfunction

  // ---------------- instruction-level model ----------------
  function automatic logic [11:0] model_fetch();
    return pack(1, 0, 0, 2'd2, 1, 1, 0, 1, 0, 1, 0);
  endfunction

  function automatic logic [11:0] model_halt();
    return pack(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic logic [11:0] model_reset();
    return pack(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  function automatic logic [11:0] model_jump();
    return pack(0, 1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [11:0] model_exec(input logic [3:0] op, input logic nf, input logic zf);
    logic [11:0] v;
    v = '0;
    if (op == 4'd0)      v = pack(0, 0, 1, 2'd0, 0, 0, 1, 1, 0, 0, 0); // LDA
    else if (op == 4'd1) v = pack(0, 0, 1, 2'd0, 0, 0, 0, 0, 1, 0, 0); // STA
    else if (op == 4'd2) v = pack(0, 0, 1, 2'd1, 0, 0, 1, 1, 0, 0, 0); // ADD
    else if (op == 4'd3) v = pack(0, 0, 1, 2'd3, 0, 0, 1, 1, 0, 0, 0); // SUB
    else if (op == 4'd4) v = model_jump();
    else if (op == 4'd5) v = nf ? 12'd0 : model_jump();
    else if (op == 4'd6) v = zf ? 12'd0 : model_jump();
    return v; // STP and undefined: all zero
  endfunction

  function automatic bit model_stops(input logic [3:0] op);
    return (op >= 4'd7);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [11:0] exp_v);
    checks++;
    if (w_dut !== exp_v) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, w_dut, exp_v);
    end
    if (rd === 1'b1 && wr === 1'b1) begin
      errors++;
      $display("FAIL %s_rdwr t=%0t rd and wr both high", nm, $time);
    end
  endtask

  // One clock cycle: drive inputs (called at posedge+1), compare at negedge.
  task automatic step(input logic [11:0] exp_v, input logic [3:0] fi, input logic ni,
                      input logic zi, input string nm);
    f = fi; n = ni; z = zi;
    @(negedge clk);
    check(nm, exp_v);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic ni, input logic zi,
                           input logic [11:0] exp_exec, input string nm);
    // Opcode and flags are garbage during fetch; outputs must ignore them.
    step(model_fetch(), 4'($urandom), 1'($urandom), 1'($urandom), {nm, "_fetch"});
    step(exp_exec, op, ni, zi, {nm, "_exec"});
    $display("INSTR %s f=%h n=%0d z=%0d", nm, op, ni, zi);
  endtask

  task automatic halt_hold(input int cycles, input string nm);
    for (int k = 0; k < cycles; k++)
      step(model_halt(), 4'($urandom), 1'($urandom), 1'($urandom), nm);
  endtask

  // Reset asserted at posedge+1, held over one rising edge, released at posedge+1.
  task automatic reset_pulse(input string nm);
    reset = 1'b1;
    #1;
    check({nm, "_now"}, model_reset());
    @(posedge clk);
    #1;
    check({nm, "_held"}, model_reset());
    reset = 1'b0;
  endtask

  // Reset arriving in the middle of an EXEC cycle that would load Acc.
  task automatic abort_exec(input string nm);
    step(model_fetch(), 4'($urandom), 1'($urandom), 1'($urandom), {nm, "_fetch"});
    f = 4'd2; n = 1'b0; z = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check({nm, "_abort"}, model_reset());
    @(posedge clk);
    #1;
    check({nm, "_held"}, model_reset());
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    logic       nn, zz;
    int         r;

    reset = 1'b0; f = '0; n = 1'b0; z = 1'b0;
    #1 reset = 1'b1;
    #1 check("reset_init", pack(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk);
    #1;
    check("reset_after_edge", pack(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
    reset = 1'b0;

    // Directed instructions with literal expectations.
    step(pack(1, 0, 0, 2'd2, 1, 1, 0, 1, 0, 1, 0), 4'd2, 0, 0, "add_fetch_lit");
    step(pack(0, 0, 1, 2'd1, 0, 0, 1, 1, 0, 0, 0), 4'd2, 0, 0, "add_exec_lit");
    run_instr(4'd5, 1, 0, 12'd0, "jge_n1_lit");
    run_instr(4'd5, 0, 1, pack(0, 1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0), "jge_n0_lit");
    run_instr(4'd6, 0, 1, 12'd0, "jne_z1_lit");
    run_instr(4'd6, 1, 0, pack(0, 1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0), "jne_z0_lit");
    run_instr(4'd1, 1, 1, pack(0, 0, 1, 2'd0, 0, 0, 0, 0, 1, 0, 0), "sta_lit");
    run_instr(4'd0, 0, 0, pack(0, 0, 1, 2'd0, 0, 0, 1, 1, 0, 0, 0), "lda_lit");
    run_instr(4'd3, 0, 0, pack(0, 0, 1, 2'd3, 0, 0, 1, 1, 0, 0, 0), "sub_lit");
    run_instr(4'd7, 0, 0, 12'd0, "stp_lit");
    halt_hold(10, "stp_halt");
    reset_pulse("stp_reset");
    run_instr(4'hC, 0, 0, 12'd0, "undef_c_lit");
    halt_hold(12, "undef_halt");
    reset_pulse("undef_reset");
    abort_exec("abort_lit");

    // Randomized instruction stream against the model.
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 99);
      nn = 1'($urandom);
      zz = 1'($urandom);
      if (r < 3) begin
        abort_exec("rnd_abort");
      end else begin
        if (r < 8) op = 4'($urandom_range(7, 15));
        else       op = 4'($urandom_range(0, 6));
        run_instr(op, nn, zz, model_exec(op, nn, zz), "rnd");
        if (model_stops(op)) begin
          halt_hold(10 + $urandom_range(0, 4), "rnd_halt");
          reset_pulse("rnd_reset");
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
